// File: rtl/ysyx_lsu.sv
// Load/store unit: takes one execute-stage request at a time and moves it onto a
// 32-bit AXI4-Lite-style master port. Returns extended load data or a store completion.
module ysyx_lsu #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic             lsu_ren,
  input  logic             lsu_wen,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic [3:0]       lsu_op,
  input  logic [BIT_W-1:0] lsu_wdata,
  output logic [BIT_W-1:0] lsu_rdata_o,
  output logic             lsu_exu_rvalid_o,
  output logic             lsu_exu_wready_o,
  output logic             lsu_err_o,
  output logic [BIT_W-1:0] araddr_o,
  output logic             arvalid_o,
  input  logic             arready,
  input  logic [BIT_W-1:0] rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready_o,
  output logic [BIT_W-1:0] awaddr_o,
  output logic             awvalid_o,
  input  logic             awready,
  output logic [BIT_W-1:0] wdata_o,
  output logic [3:0]       wstrb_o,
  output logic             wvalid_o,
  input  logic             wready,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready_o
);

  typedef enum logic [2:0] {IDLE, AR, R, AW, B, RESP} state_t;
  typedef struct packed {
    logic       is_load;
    logic [2:0] op;
    logic [1:0] sh;
  } req_t;

  state_t state, nxt;
  req_t   req;

  logic             accept, misalign, bad_op;
  logic [15:0]      sft;
  logic [BIT_W-1:0] ld_ext;
  logic [3:0]       st_strb;
  logic [BIT_W-1:0] st_data;
  logic             unused_op3;

  assign unused_op3 = lsu_op[3];
  assign accept     = lsu_avalid & (lsu_ren | lsu_wen);
  assign misalign   = (lsu_op[1:0] == 2'b01 && lsu_addr[0]) ||
                      (lsu_op[2:0] == 3'b010 && lsu_addr[1:0] != 2'b00);

  // Only the low halfword of the shifted beat is ever needed.
  assign sft = 16'(rdata >> {req.sh, 3'b000});

  always_comb begin
    ld_ext = '0;
    bad_op = 1'b0;
    case (req.op)
      3'd0:    ld_ext = {{(BIT_W-8){sft[7]}}, sft[7:0]};
      3'd4:    ld_ext = {{(BIT_W-8){1'b0}}, sft[7:0]};
      3'd1:    ld_ext = {{(BIT_W-16){sft[15]}}, sft};
      3'd5:    ld_ext = {{(BIT_W-16){1'b0}}, sft};
      3'd2:    ld_ext = rdata;
      default: bad_op = 1'b1;
    endcase
  end

  always_comb begin
    st_strb = 4'hF;
    st_data = lsu_wdata;
    case (lsu_op[1:0])
      2'b00: begin
        st_strb = 4'b0001 << lsu_addr[1:0];
        st_data = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << lsu_addr[1:0];
        st_data = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = misalign ? RESP : (lsu_ren ? AR : AW);
      AR:   if (arready) nxt = R;
      R:    if (rvalid) nxt = RESP;
      // Each channel is finished once its valid has dropped or is handshaking now.
      AW:   if ((!awvalid_o || awready) && (!wvalid_o || wready)) nxt = B;
      B:    if (bvalid) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rready_o         = (state == R);
    bready_o         = (state == B);
    lsu_exu_rvalid_o = (state == RESP) &  req.is_load;
    lsu_exu_wready_o = (state == RESP) & ~req.is_load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req         <= '0;
      lsu_rdata_o <= '0;
      lsu_err_o   <= 1'b0;
      araddr_o    <= '0;
      arvalid_o   <= 1'b0;
      awaddr_o    <= '0;
      awvalid_o   <= 1'b0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      wvalid_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req       <= '{is_load: lsu_ren, op: lsu_op[2:0], sh: lsu_addr[1:0]};
          lsu_err_o <= 1'b0;
          if (misalign) begin
            lsu_err_o <= 1'b1;
            if (lsu_ren) lsu_rdata_o <= '0;
          end else if (lsu_ren) begin
            arvalid_o <= 1'b1;
            araddr_o  <= {lsu_addr[BIT_W-1:2], 2'b00};
          end else begin
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            awaddr_o  <= {lsu_addr[BIT_W-1:2], 2'b00};
            wdata_o   <= st_data;
            wstrb_o   <= st_strb;
          end
        end
        AR: if (arready) arvalid_o <= 1'b0;
        R: if (rvalid) begin
          lsu_rdata_o <= ld_ext;
          lsu_err_o   <= (rresp != 2'b00) | bad_op;
        end
        AW: begin
          if (awready) awvalid_o <= 1'b0;
          if (wready)  wvalid_o  <= 1'b0;
        end
        B: if (bvalid) lsu_err_o <= (bresp != 2'b00);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu: hand-computed vectors checked with immediate assertions.
module tb_ysyx_lsu;

  logic        clk, rst;
  logic        lsu_avalid, lsu_ren, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_op;
  logic [31:0] lsu_rdata_o;
  logic        lsu_exu_rvalid_o, lsu_exu_wready_o, lsu_err_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready_o;

  ysyx_lsu #(.BIT_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_avalid(lsu_avalid), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_op(lsu_op), .lsu_wdata(lsu_wdata),
    .lsu_rdata_o(lsu_rdata_o), .lsu_exu_rvalid_o(lsu_exu_rvalid_o),
    .lsu_exu_wready_o(lsu_exu_wready_o), .lsu_err_o(lsu_err_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready_o(rready_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready(awready),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready_o(bready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          lat;
  logic        saw_ar, saw_w, got_load, got_err;
  logic [31:0] got_data, cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request at a negedge and wait (bounded) for its done pulse.
  task automatic xact(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] op, input logic [31:0] wd);
    lsu_avalid = 1'b1; lsu_ren = r; lsu_wen = w;
    lsu_addr = a; lsu_op = op; lsu_wdata = wd;
    lat = 0; saw_ar = 0; saw_w = 0; got_load = 0; got_err = 0; got_data = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (arvalid_o && !saw_ar) begin saw_ar = 1; cap_araddr = araddr_o; end
      if (wvalid_o && !saw_w) begin
        saw_w = 1; cap_awaddr = awaddr_o; cap_wdata = wdata_o; cap_wstrb = wstrb_o;
      end
      if (lsu_exu_rvalid_o || lsu_exu_wready_o) begin
        lat = i; got_load = lsu_exu_rvalid_o; got_err = lsu_err_o; got_data = lsu_rdata_o;
        break;
      end
    end
    lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    lsu_avalid = 0; lsu_ren = 0; lsu_wen = 0; lsu_addr = '0; lsu_op = '0; lsu_wdata = '0;
    arready = 1; rvalid = 1; rdata = '0; rresp = '0;
    awready = 1; wready = 1; bvalid = 1; bresp = '0;
    #2;
    chk("reset_valids", {31'd0, arvalid_o | awvalid_o | wvalid_o | rready_o | bready_o}, 32'd0);
    chk("reset_done", {30'd0, lsu_exu_rvalid_o, lsu_exu_wready_o}, 32'd0);
    chk("reset_rdata", lsu_rdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // LB at 0x80000003, zero-wait bus, cycle by cycle.
    rdata = 32'h80FF_1234;
    lsu_avalid = 1; lsu_ren = 1; lsu_addr = 32'h8000_0003; lsu_op = 4'd0;
    step();
    chk("lb_c1_arvalid", {31'd0, arvalid_o}, 32'd1);
    chk("lb_c1_araddr", araddr_o, 32'h8000_0000);
    step();
    chk("lb_c2_arvalid", {31'd0, arvalid_o}, 32'd0);
    chk("lb_c2_rready", {31'd0, rready_o}, 32'd1);
    step();
    chk("lb_c3_rvalid", {31'd0, lsu_exu_rvalid_o}, 32'd1);
    chk("lb_c3_data", lsu_rdata_o, 32'hFFFF_FF80);
    chk("lb_c3_err", {31'd0, lsu_err_o}, 32'd0);
    lsu_avalid = 0; lsu_ren = 0;
    step();
    chk("lb_c4_no_pulse", {31'd0, lsu_exu_rvalid_o}, 32'd0);

    // LHU at 0x102.
    rdata = 32'hBEEF_0000;
    xact(1, 0, 32'h102, 4'd5, '0);
    chk("lhu_lat", lat, 3);
    chk("lhu_data", got_data, 32'h0000_BEEF);
    chk("lhu_err", {31'd0, got_err}, 32'd0);
    step();

    // LBU at 0x001.
    rdata = 32'h0000_8000;
    xact(1, 0, 32'h001, 4'd4, '0);
    chk("lbu_data", got_data, 32'h0000_0080);
    step();

    // LH misaligned at 0x101: immediate error, no bus traffic.
    xact(1, 0, 32'h101, 4'd1, '0);
    chk("lh_mis_lat", lat, 1);
    chk("lh_mis_err", {31'd0, got_err}, 32'd1);
    chk("lh_mis_data", got_data, 32'd0);
    chk("lh_mis_no_ar", {31'd0, saw_ar}, 32'd0);
    step();

    // SB 0xA5 at 0x202: awready late by 3 cycles, wready immediate.
    awready = 0; bvalid = 0;
    lsu_avalid = 1; lsu_wen = 1; lsu_addr = 32'h202; lsu_op = 4'd0; lsu_wdata = 32'h0000_00A5;
    step();
    chk("sb_c1_wstrb", {28'd0, wstrb_o}, 32'h4);
    chk("sb_c1_wdata", wdata_o, 32'hA5A5_A5A5);
    chk("sb_c1_awaddr", awaddr_o, 32'h200);
    chk("sb_c1_valids", {30'd0, awvalid_o, wvalid_o}, 32'd3);
    step();
    chk("sb_c2_valids", {30'd0, awvalid_o, wvalid_o}, 32'd2);
    step();
    chk("sb_c3_valids", {30'd0, awvalid_o, wvalid_o}, 32'd2);
    awready = 1;
    step();
    chk("sb_c4_valids", {30'd0, awvalid_o, wvalid_o}, 32'd0);
    chk("sb_c4_bready", {31'd0, bready_o}, 32'd1);
    chk("sb_c4_no_done", {31'd0, lsu_exu_wready_o}, 32'd0);
    bvalid = 1;
    step();
    chk("sb_c5_done", {31'd0, lsu_exu_wready_o}, 32'd1);
    chk("sb_c5_err", {31'd0, lsu_err_o}, 32'd0);
    lsu_avalid = 0; lsu_wen = 0;
    step();
    chk("sb_c6_single", {31'd0, lsu_exu_wready_o}, 32'd0);

    // SH 0xBEEF at 0x102.
    xact(0, 1, 32'h102, 4'd1, 32'h1234_BEEF);
    chk("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_lat", lat, 3);
    step();

    // SW with SLVERR, then LW with DECERR.
    bresp = 2'b10;
    xact(0, 1, 32'h300, 4'd2, 32'hDEAD_BEEF);
    chk("sw_err_kind", {31'd0, got_load}, 32'd0);
    chk("sw_err_err", {31'd0, got_err}, 32'd1);
    chk("sw_err_wstrb", {28'd0, cap_wstrb}, 32'hF);
    bresp = 2'b00;
    step();
    rresp = 2'b11; rdata = 32'hCAFE_F00D;
    xact(1, 0, 32'h500, 4'd2, '0);
    chk("lw_err_kind", {31'd0, got_load}, 32'd1);
    chk("lw_err_err", {31'd0, got_err}, 32'd1);
    rresp = 2'b00;
    step();

    // Unsupported load op 3 goes to the bus but returns error and zero.
    rdata = 32'hFFFF_FFFF;
    xact(1, 0, 32'h600, 4'd3, '0);
    chk("op3_lat", lat, 3);
    chk("op3_err", {31'd0, got_err}, 32'd1);
    chk("op3_data", got_data, 32'd0);
    step();

    // Asynchronous reset while waiting in R.
    rvalid = 0;
    lsu_avalid = 1; lsu_ren = 1; lsu_addr = 32'h400; lsu_op = 4'd2;
    step();
    step();
    chk("rst_pre_rready", {31'd0, rready_o}, 32'd1);
    #2 rst = 0; lsu_avalid = 0; lsu_ren = 0;
    #1;
    chk("rst_async_ctl", {24'd0, rready_o, arvalid_o, awvalid_o, wvalid_o, bready_o,
                          lsu_exu_rvalid_o, lsu_exu_wready_o, lsu_err_o}, 32'd0);
    chk("rst_async_araddr", araddr_o, 32'd0);
    chk("rst_async_rdata", lsu_rdata_o, 32'd0);
    @(negedge clk);
    rst = 1; rvalid = 1; rdata = 32'h1234_5678;
    step();
    xact(1, 0, 32'h404, 4'd2, '0);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", got_data, 32'h1234_5678);
    chk("post_rst_araddr", cap_araddr, 32'h404);

    // Back-to-back LW then SW, second asserted in the cycle after RESP.
    rdata = 32'h0BAD_F00D;
    xact(1, 0, 32'h700, 4'd2, '0);
    chk("b2b_lw_data", got_data, 32'h0BAD_F00D);
    step();
    chk("b2b_no_dup", {30'd0, lsu_exu_rvalid_o, lsu_exu_wready_o}, 32'd0);
    xact(0, 1, 32'h704, 4'd2, 32'h5555_AAAA);
    chk("b2b_sw_lat", lat, 3);
    chk("b2b_sw_kind", {31'd0, got_load}, 32'd0);
    chk("b2b_sw_addr", cap_awaddr, 32'h704);
    step();
    chk("b2b_sw_no_dup", {30'd0, lsu_exu_rvalid_o, lsu_exu_wready_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
